// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, start, 8 data,
// odd parity, stop, device ACK) driving open-drain pins via output enables.
// Ports:
//   clk, rstn               system clock, asynchronous active-low reset
//   tx_data[7:0], tx_start  byte to send and its single-cycle request
//   ps2_clk_in, ps2_data_in raw (asynchronous) pin levels
//   ps2_clk_oe, ps2_data_oe 1 = pull the pin low, 0 = release it
//   busy                    transfer in progress (accept cycle .. cycle after done)
//   done, err               end-of-transfer pulse; err = NACK or timeout
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 12000,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned SH_W    = 10;

  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(11);
  localparam logic [BIT_W-1:0] BIT_PAR  = BIT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_STOP, S_WAIT_IDLE, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              nack_q, nack_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [1:0]        clk_sync_q, data_sync_q;
  logic              clk_prev_q;
  logic              clk_s_c, data_s_c, fall_c;

  // Pin synchronizers plus one extra stage for falling-edge detection; idle bus is high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s_c  = clk_sync_q[1];
  assign data_s_c = data_sync_q[1];
  assign fall_c   = clk_prev_q & ~clk_s_c;

  // State and registered outputs; reset releases both pins immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    nack_d    = nack_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_start) begin
          sh_d     = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          bit_d    = '0;
          nack_d   = 1'b0;
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      // Host holds the clock low; falling edges here are our own and ignored
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == INH_PRE) begin
          data_oe_d = 1'b1;
        end
        if (cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end

      S_REQ, S_DATA, S_STOP, S_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TMO_LAST) begin
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = S_FIN;
        end else begin
          unique case (state_q)
            // Edges 1..10 shift out data, parity and finally stop (releases data)
            S_REQ, S_DATA: begin
              if (fall_c) begin
                bit_d     = (bit_q == BIT_MAX) ? bit_q : bit_q + BIT_W'(1);
                data_oe_d = ~sh_q[0];
                sh_d      = {1'b0, sh_q[SH_W-1:1]};
                state_d   = (bit_q == BIT_PAR) ? S_STOP : S_DATA;
              end
            end
            // Edge 11: device pulls data low to acknowledge
            S_STOP: begin
              if (fall_c) begin
                bit_d   = (bit_q == BIT_MAX) ? bit_q : bit_q + BIT_W'(1);
                nack_d  = data_s_c;
                state_d = S_WAIT_IDLE;
              end
            end
            S_WAIT_IDLE: begin
              if (clk_s_c && data_s_c) begin
                done_d  = 1'b1;
                err_d   = nack_q;
                state_d = S_FIN;
              end
            end
            default: ;
          endcase
        end
      end

      S_FIN: begin
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model
// (device clock half period HALF cycles, open-drain wired-AND pin model).
module tb_ps2_host_tx;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic       dev_clk, dev_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  ps2_host_tx #(.INHIBIT_CYC(200), .TIMEOUT_CYC(5000)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device: wait for request-to-send, clock n_edges, sample on rising edges
  task automatic device_frame(input int n_edges, input bit ack,
                              output logic [9:0] bits, output bit seen);
    int g;
    bits = '0;
    g = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    seen = (g < 1000);
    if (seen) begin
      repeat (5) @(negedge clk);
      for (int i = 1; i <= n_edges; i++) begin
        if (i == 11 && ack) begin
          dev_data = 1'b0;
          repeat (2) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (i <= 10) bits[i-1] = ps2_data_in;
        repeat (HALF) @(negedge clk);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(output bit got, output logic e, output logic coe,
                           output logic doe, output logic busy_after);
    int g;
    got = 1'b0; e = 1'bx; coe = 1'bx; doe = 1'bx; busy_after = 1'bx;
    g = 0;
    while (!got && g < 3000) begin
      @(negedge clk);
      g++;
      if (done === 1'b1) begin
        got = 1'b1; e = err; coe = ps2_clk_oe; doe = ps2_data_oe;
      end
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, output logic [9:0] bits,
                           output bit seen, output bit got, output logic e,
                           output logic coe, output logic doe, output logic busy_after);
    send(d);
    fork
      device_frame(11, ack, bits, seen);
      wait_done(got, e, coe, doe, busy_after);
    join
  endtask

  task automatic test_reset();
    rstn = 1'b0; tx_start = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed();
    logic [9:0] bits; bit seen, got; logic e, coe, doe, ba;
    run_frame(8'hED, 1'b1, bits, seen, got, e, coe, doe, ba);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ed_request: got %b expected 1", seen); end
    n_checks++; if (bits !== 10'b11_1110_1101) begin n_fail++; $display("FAIL ed_bits: got %b expected 1111101101", bits); end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL ed_done: got %b expected 1", got); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL ed_err: got %b expected 0", e); end
    n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL ed_busy_after: got %b expected 0", ba); end
  endtask

  task automatic test_timing_01();
    logic [9:0] bits; bit seen, got; logic e, coe, doe, ba;
    int low_cnt, first_doe, first_rel;
    low_cnt = 0; first_doe = 0; first_rel = 0;
    send(8'h01);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t01_busy_t1: got %b expected 1", busy); end
    for (int k = 1; k <= 202; k++) begin
      if (k > 1) @(negedge clk);
      if (ps2_clk_oe === 1'b1) low_cnt++;
      if (ps2_data_oe === 1'b1 && first_doe == 0) first_doe = k;
      if (ps2_clk_oe === 1'b0 && first_rel == 0) first_rel = k;
    end
    n_checks++; if (low_cnt !== 200) begin n_fail++; $display("FAIL t01_clk_low_cycles: got %0d expected 200", low_cnt); end
    n_checks++; if (first_doe !== 200) begin n_fail++; $display("FAIL t01_data_oe_cycle: got %0d expected 200", first_doe); end
    n_checks++; if (first_rel !== 201) begin n_fail++; $display("FAIL t01_clk_release_cycle: got %0d expected 201", first_rel); end
    fork
      device_frame(11, 1'b1, bits, seen);
      wait_done(got, e, coe, doe, ba);
    join
    n_checks++; if (bits !== 10'b10_0000_0001) begin n_fail++; $display("FAIL t01_bits: got %b expected 1000000001", bits); end
    n_checks++; if (got !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL t01_done_err: got %b/%b expected 1/0", got, e); end
  endtask

  task automatic test_nack();
    logic [9:0] bits; bit seen, got; logic e, coe, doe, ba;
    run_frame(8'hFF, 1'b0, bits, seen, got, e, coe, doe, ba);
    n_checks++; if (bits !== 10'b11_1111_1111) begin n_fail++; $display("FAIL nack_bits: got %b expected 1111111111", bits); end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL nack_done: got %b expected 1", got); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL nack_err: got %b expected 1", e); end
    n_checks++; if (coe !== 1'b0 || doe !== 1'b0) begin n_fail++; $display("FAIL nack_oe: got %b%b expected 00", coe, doe); end
  endtask

  task automatic test_timeout();
    int k, k_req, k_done;
    logic prev_doe, d_coe, d_doe, d_err;
    k = 1; k_req = 0; k_done = 0; prev_doe = 1'b0; d_coe = 1'bx; d_doe = 1'bx; d_err = 1'bx;
    send(8'hA5);
    while (ps2_clk_oe !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    k_req = k;
    while (k_done == 0 && k < k_req + 6000) begin
      prev_doe = ps2_data_oe;
      @(negedge clk); k++;
      if (done === 1'b1) begin k_done = k; d_coe = ps2_clk_oe; d_doe = ps2_data_oe; d_err = err; end
    end
    n_checks++; if (k_done - k_req !== 5000) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 5000", k_done - k_req); end
    n_checks++; if (prev_doe !== 1'b1) begin n_fail++; $display("FAIL tmo_doe_before: got %b expected 1", prev_doe); end
    n_checks++; if (d_coe !== 1'b0 || d_doe !== 1'b0) begin n_fail++; $display("FAIL tmo_oe: got %b%b expected 00", d_coe, d_doe); end
    n_checks++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", d_err); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_start_while_busy();
    logic [9:0] bits; bit seen, got; logic e, coe, doe, ba;
    int base, extra_low;
    base = done_cnt; extra_low = 0;
    send(8'hED);
    fork
      device_frame(11, 1'b1, bits, seen);
      wait_done(got, e, coe, doe, ba);
      begin
        repeat (250) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_frame: got %b expected 1", busy); end
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; tx_data = 8'hED;
      end
    join
    n_checks++; if (bits !== 10'b11_1110_1101) begin n_fail++; $display("FAIL busy_bits: got %b expected 1111101101", bits); end
    n_checks++; if (got !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL busy_done_err: got %b/%b expected 1/0", got, e); end
    repeat (400) begin
      @(negedge clk);
      if (ps2_clk_oe === 1'b1 || busy === 1'b1) extra_low++;
    end
    n_checks++; if (extra_low !== 0) begin n_fail++; $display("FAIL busy_no_second_frame: got %0d active cycles expected 0", extra_low); end
    n_checks++; if (done_cnt - base !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt - base); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits; bit seen, got; logic e, coe, doe, ba;
    send(8'hF0);
    device_frame(4, 1'b0, bits, seen);
    n_checks++; if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got oe=%b busy=%b expected 1/1", ps2_data_oe, busy); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got %b%b expected 00", ps2_clk_oe, ps2_data_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(8'h3C, 1'b1, bits, seen, got, e, coe, doe, ba);
    n_checks++; if (bits !== 10'b11_0011_1100) begin n_fail++; $display("FAIL rst_fresh_bits: got %b expected 1100111100", bits); end
    n_checks++; if (got !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_done_err: got %b/%b expected 1/0", got, e); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_timing_01();
    test_nack();
    test_timeout();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
